// File: rtl/ecpeta_err_monitor_pkg.sv
// Shared ECPETA definitions: default widths, monitor FSM states and ED width helper.
package ecpeta_pkg;

    localparam int N_DEF = 16;
    localparam int K_DEF = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SAT  = 2'd2
    } state_t;

    // Error distance needs one bit more than the operands (carry of the exact sum).
    function automatic int ed_w(input int n);
        return n + 1;
    endfunction

endpackage

// File: rtl/ecpeta_err_monitor_if.sv
// Sample bus into the error monitor: operands, approximate sum and valid/ready handshake.
interface ecpeta_err_monitor_if
    import ecpeta_pkg::*;
#(
    parameter int N = N_DEF
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] sum_apx;

    modport master (output in_valid, a, b, sum_apx, input in_ready);
    modport slave  (input in_valid, a, b, sum_apx, output in_ready);
endinterface

// File: rtl/ecpeta_err_monitor_acc.sv
// Stage-3 statistics: sample/error counters, ED sum, max/last ED and the
// saturation compare that keeps the counters from ever wrapping.
module ecpeta_err_acc
    import ecpeta_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int CNT_W = 32
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 i_vld,
    input  logic [N:0]           i_ed,
    input  logic                 i_nz,
    input  logic [1:0]           i_inflight,
    output logic [CNT_W-1:0]     o_sample_cnt,
    output logic [CNT_W-1:0]     o_err_cnt,
    output logic [CNT_W+N:0]     o_ed_acc,
    output logic [N:0]           o_ed_max,
    output logic [N:0]           o_ed_last,
    output logic                 o_at_limit
);
    localparam logic [CNT_W:0] LIMIT = {1'b0, {CNT_W{1'b1}}};

    logic [CNT_W-1:0] r_sample_cnt;
    logic [CNT_W-1:0] r_err_cnt;
    logic [CNT_W+N:0] r_ed_acc;
    logic [N:0]       r_ed_max;
    logic [N:0]       r_ed_last;
    logic [CNT_W:0]   w_total;

    // Samples already counted plus those still travelling through stages 1-2.
    assign w_total    = {1'b0, r_sample_cnt} + {{(CNT_W-1){1'b0}}, i_inflight};
    assign o_at_limit = (w_total >= LIMIT);

    // Statistics update at the last pipeline edge; clear wins over a valid sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sample_cnt <= '0;
            r_err_cnt    <= '0;
            r_ed_acc     <= '0;
            r_ed_max     <= '0;
            r_ed_last    <= '0;
        end else if (clear) begin
            r_sample_cnt <= '0;
            r_err_cnt    <= '0;
            r_ed_acc     <= '0;
            r_ed_max     <= '0;
            r_ed_last    <= '0;
        end else if (i_vld) begin
            r_sample_cnt <= r_sample_cnt + CNT_W'(1);
            r_err_cnt    <= r_err_cnt + {{(CNT_W-1){1'b0}}, i_nz};
            r_ed_acc     <= r_ed_acc + {{CNT_W{1'b0}}, i_ed};
            r_ed_last    <= i_ed;
            if (i_ed > r_ed_max) begin
                r_ed_max <= i_ed;
            end
        end
    end

    assign o_sample_cnt = r_sample_cnt;
    assign o_err_cnt    = r_err_cnt;
    assign o_ed_acc     = r_ed_acc;
    assign o_ed_max     = r_ed_max;
    assign o_ed_last    = r_ed_last;

endmodule

// File: rtl/ecpeta_err_monitor.sv
// Approximate-adder error monitor: capture stage, ED stage, statistics stage and
// IDLE/RUN/SAT control that throttles input before the counters can overflow.
module ecpeta_err_monitor
    import ecpeta_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int K     = K_DEF,
    parameter int CNT_W = 32
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    ecpeta_err_monitor_if.slave   bus,
    output logic [CNT_W-1:0]      sample_cnt,
    output logic [CNT_W-1:0]      err_cnt,
    output logic [CNT_W+N:0]      ed_acc,
    output logic [ed_w(N)-1:0]    ed_max,
    output logic [ed_w(N)-1:0]    ed_last,
    output logic                  sat
);
    // K only describes the adder under test; reject nonsensical values at elaboration.
    if (K < 1 || K > N) begin : g_k_check
        $error("ecpeta_err_monitor: K must lie in 1..N");
    end

    state_t       r_state;
    state_t       w_state_nxt;

    logic         r_s1_vld;
    logic [N-1:0] r_s1_a;
    logic [N-1:0] r_s1_b;
    logic [N-1:0] r_s1_sum;
    logic         r_s2_vld;
    logic [N:0]   r_s2_ed;
    logic         r_s2_nz;

    logic         w_accept;
    logic         w_at_limit;
    logic [1:0]   w_inflight;
    logic [N:0]   w_exact;
    logic [N:0]   w_apx;
    logic [N:0]   w_ed;

    assign bus.in_ready = !clear && (r_state != SAT) && !w_at_limit;
    assign w_accept     = bus.in_valid && bus.in_ready;
    assign w_inflight   = {1'b0, r_s1_vld} + {1'b0, r_s2_vld};
    assign sat          = (r_state == SAT);

    assign w_exact = {1'b0, r_s1_a} + {1'b0, r_s1_b};
    assign w_apx   = {1'b0, r_s1_sum};
    assign w_ed    = (w_exact >= w_apx) ? (w_exact - w_apx) : (w_apx - w_exact);

    // Stage 1: capture an accepted sample (accept is already low during clear).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld <= 1'b0;
            r_s1_a   <= '0;
            r_s1_b   <= '0;
            r_s1_sum <= '0;
        end else begin
            r_s1_vld <= w_accept;
            if (w_accept) begin
                r_s1_a   <= bus.a;
                r_s1_b   <= bus.b;
                r_s1_sum <= bus.sum_apx;
            end
        end
    end

    // Stage 2: register the error distance and its nonzero flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_vld <= 1'b0;
            r_s2_ed  <= '0;
            r_s2_nz  <= 1'b0;
        end else begin
            r_s2_vld <= r_s1_vld && !clear;
            if (r_s1_vld) begin
                r_s2_ed <= w_ed;
                r_s2_nz <= (w_ed != '0);
            end
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: first accept starts a run, reaching the count limit saturates.
    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_accept)   w_state_nxt = RUN;
                RUN:     if (w_at_limit) w_state_nxt = SAT;
                SAT:     w_state_nxt = SAT;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    ecpeta_err_acc #(
        .N     (N),
        .CNT_W (CNT_W)
    ) u_acc (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (clear),
        .i_vld        (r_s2_vld),
        .i_ed         (r_s2_ed),
        .i_nz         (r_s2_nz),
        .i_inflight   (w_inflight),
        .o_sample_cnt (sample_cnt),
        .o_err_cnt    (err_cnt),
        .o_ed_acc     (ed_acc),
        .o_ed_max     (ed_max),
        .o_ed_last    (ed_last),
        .o_at_limit   (w_at_limit)
    );

endmodule

// File: tb/tb_ecpeta_err_monitor.sv
// Bench for the ECPETA error monitor: directed vector table, hand-written corner
// sequences and a randomized stream against a sample-queue reference model.
module tb_ecpeta_err_monitor;
    import ecpeta_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    logic clear4 = 1'b0;

    always #5 clk = ~clk;

    ecpeta_err_monitor_if #(.N(16)) bus ();
    ecpeta_err_monitor_if #(.N(16)) bus4 ();

    logic [31:0] sample_cnt, err_cnt;
    logic [48:0] ed_acc;
    logic [16:0] ed_max, ed_last;
    logic        sat;

    logic [3:0]  sample_cnt4, err_cnt4;
    logic [20:0] ed_acc4;
    logic [16:0] ed_max4, ed_last4;
    logic        sat4;

    ecpeta_err_monitor #(.N(16), .K(7), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus),
        .sample_cnt(sample_cnt), .err_cnt(err_cnt), .ed_acc(ed_acc),
        .ed_max(ed_max), .ed_last(ed_last), .sat(sat)
    );

    ecpeta_err_monitor #(.N(16), .K(7), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .clear(clear4), .bus(bus4),
        .sample_cnt(sample_cnt4), .err_cnt(err_cnt4), .ed_acc(ed_acc4),
        .ed_max(ed_max4), .ed_last(ed_last4), .sat(sat4)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (main instance, 32-bit counters) ----------------
    localparam longint unsigned MAXC = 64'hFFFF_FFFF;
    longint unsigned m_cnt, m_err, m_acc, m_max, m_last;
    bit m_sat;
    int pipe[$];   // samples accepted but not yet counted: ED value, or -1 for an empty slot

    function automatic int ref_ed(input logic [15:0] a, input logic [15:0] b, input logic [15:0] s);
        int d;
        d = int'(a) + int'(b) - int'(s);
        return (d < 0) ? -d : d;
    endfunction

    function automatic int m_inflight();
        int n = 0;
        foreach (pipe[i]) if (pipe[i] >= 0) n++;
        return n;
    endfunction

    function automatic bit m_ready();
        return !clear && !m_sat && ((m_cnt + longint'(m_inflight())) < MAXC);
    endfunction

    task automatic m_reset();
        m_cnt = 0; m_err = 0; m_acc = 0; m_max = 0; m_last = 0; m_sat = 0;
        pipe = {-1, -1};
    endtask

    task automatic m_edge();
        bit acc;
        longint unsigned total;
        int old;
        acc   = bus.in_valid && m_ready();
        total = m_cnt + longint'(m_inflight());
        old   = pipe.pop_front();
        if (clear) begin
            m_cnt = 0; m_err = 0; m_acc = 0; m_max = 0; m_last = 0; m_sat = 0;
            pipe = {-1, -1};
        end else begin
            if (old >= 0) begin
                m_cnt++;
                if (old != 0) m_err++;
                m_acc += longint'(old);
                if (longint'(old) > m_max) m_max = longint'(old);
                m_last = longint'(old);
            end
            pipe.push_back(acc ? ref_ed(bus.a, bus.b, bus.sum_apx) : -1);
            if (total == MAXC) m_sat = 1;
        end
    endtask

    task automatic check_outputs();
        chk("sample_cnt", sample_cnt, m_cnt);
        chk("err_cnt", err_cnt, m_err);
        chk("ed_acc", ed_acc, m_acc);
        chk("ed_max", ed_max, m_max);
        chk("ed_last", ed_last, m_last);
        chk("sat", sat, m_sat);
        chk("in_ready", bus.in_ready, m_ready());
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        if (rst_n) m_edge();
        #1;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) cycle();
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [15:0] s);
        bus.a = a; bus.b = b; bus.sum_apx = s; bus.in_valid = 1'b1;
        cycle();
        bus.in_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        cycle();
        clear = 1'b0;
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] s;
        logic [16:0] ed;
    } vec_t;

    vec_t vecs[8];
    int   acc4;
    logic [15:0] ra, rb;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{16'h1234, 16'h5678, 16'h68AC, 17'h00000};
        vecs[1] = '{16'hFFFF, 16'h0001, 16'h0000, 17'h10000};
        vecs[2] = '{16'hAAAA, 16'h5555, 16'hFFF0, 17'h0000F};
        vecs[3] = '{16'h0F0F, 16'hF0F0, 16'hFFFF, 17'h00000};
        vecs[4] = '{16'h0000, 16'h0000, 16'hFFFF, 17'h0FFFF};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 16'h0000, 17'h1FFFE};
        vecs[6] = '{16'h0001, 16'h0002, 16'h0005, 17'h00002};
        vecs[7] = '{16'h8000, 16'h8000, 16'h0000, 17'h10000};

        bus.in_valid = 0; bus.a = 0; bus.b = 0; bus.sum_apx = 0;
        bus4.in_valid = 0; bus4.a = 0; bus4.b = 0; bus4.sum_apx = 0;
        m_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sample_cnt", sample_cnt, 0);
        chk("rst_ed_acc", ed_acc, 0);
        chk("rst_sat", sat, 0);
        rst_n = 1'b1;
        cycle();   // model expects in_ready = 1 right after release

        // Directed vector table, each sample in isolation
        foreach (vecs[i]) begin
            pulse_clear();
            send(vecs[i].a, vecs[i].b, vecs[i].s);
            idle(2);
            chk($sformatf("vec%0d_ed_last", i), ed_last, vecs[i].ed);
            chk($sformatf("vec%0d_sample_cnt", i), sample_cnt, 1);
            chk($sformatf("vec%0d_err_cnt", i), err_cnt, (vecs[i].ed != 0) ? 1 : 0);
            chk($sformatf("vec%0d_ed_acc", i), ed_acc, vecs[i].ed);
            chk($sformatf("vec%0d_ed_max", i), ed_max, vecs[i].ed);
        end

        // Back-to-back pair
        pulse_clear();
        bus.a = 16'hAAAA; bus.b = 16'h5555; bus.sum_apx = 16'hFFF0; bus.in_valid = 1;
        cycle();
        bus.a = 16'h0F0F; bus.b = 16'hF0F0; bus.sum_apx = 16'hFFFF;
        cycle();
        idle(2);
        chk("b2b_sample_cnt", sample_cnt, 2);
        chk("b2b_err_cnt", err_cnt, 1);
        chk("b2b_ed_acc", ed_acc, 15);
        chk("b2b_ed_max", ed_max, 15);
        chk("b2b_ed_last", ed_last, 0);

        // Clear with two samples in flight and in_valid held high
        pulse_clear();
        bus.a = 16'h00FF; bus.b = 16'h0001; bus.sum_apx = 16'h0000; bus.in_valid = 1;
        cycle();
        cycle();
        clear = 1'b1;
        #1;
        chk("clr_in_ready", bus.in_ready, 0);
        cycle();
        clear = 1'b0;
        bus.in_valid = 0;
        chk("clr_sample_cnt", sample_cnt, 0);
        chk("clr_ed_acc", ed_acc, 0);
        chk("clr_ed_max", ed_max, 0);
        idle(3);
        chk("clr_dropped", sample_cnt, 0);
        send(16'h0003, 16'h0004, 16'h0007);
        idle(2);
        chk("clr_resume", sample_cnt, 1);

        // Randomized stream against the model
        for (int i = 0; i < 400; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            bus.a = ra;
            bus.b = rb;
            bus.sum_apx = ($urandom_range(0, 2) == 0) ? 16'(ra + rb) : 16'($urandom);
            bus.in_valid = ($urandom_range(0, 3) != 0);
            clear = ($urandom_range(0, 39) == 0);
            cycle();
        end
        clear = 1'b0;
        idle(3);

        // Async reset mid-stream
        for (int i = 0; i < 5; i++) begin
            bus.a = 16'($urandom); bus.b = 16'($urandom); bus.sum_apx = 16'($urandom);
            bus.in_valid = 1;
            cycle();
        end
        #2;
        rst_n = 1'b0;
        #1;
        m_reset();
        chk("arst_sample_cnt", sample_cnt, 0);
        chk("arst_err_cnt", err_cnt, 0);
        chk("arst_ed_acc", ed_acc, 0);
        chk("arst_ed_last", ed_last, 0);
        chk("arst_sat", sat, 0);
        cycle();
        cycle();
        bus.in_valid = 0;
        rst_n = 1'b1;
        idle(5);
        chk("arst_no_stale", sample_cnt, 0);
        send(16'h0010, 16'h0020, 16'h0031);
        idle(2);
        chk("arst_resume_cnt", sample_cnt, 1);
        chk("arst_resume_ed", ed_last, 1);

        // 4-bit counter instance: saturation and recovery
        clear4 = 1'b1;
        cycle();
        clear4 = 1'b0;
        acc4 = 0;
        for (int i = 0; i < 20; i++) begin
            bus4.a = 16'($urandom); bus4.b = 16'($urandom); bus4.sum_apx = 16'($urandom);
            bus4.in_valid = 1'b1;
            #1;
            if (bus4.in_ready) acc4++;
            cycle();
        end
        bus4.in_valid = 1'b0;
        idle(3);
        chk("sat4_accepted", acc4, 15);
        chk("sat4_sample_cnt", sample_cnt4, 15);
        chk("sat4_sat", sat4, 1);
        chk("sat4_in_ready", bus4.in_ready, 0);
        clear4 = 1'b1;
        cycle();
        clear4 = 1'b0;
        #1;
        chk("sat4_clr_sat", sat4, 0);
        chk("sat4_clr_cnt", sample_cnt4, 0);
        chk("sat4_clr_acc", ed_acc4, 0);
        chk("sat4_clr_ready", bus4.in_ready, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
